// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: rx line config owner with idle-gated reconfig handshake and frame FIFO; `define UART_CTRL_STATS_EN adds stat_frames/stat_drops
module uart_rx_ctrl #(
  parameter logic [2:0] DEF_BAUD = 3'b010,
  parameter logic [3:0] DEF_LEN = 4'd8,
  parameter int IDLE_TICKS = 32,
  parameter int LOAD_CYCLES = 2,
  parameter int SETTLE_CYCLES = 16,
  parameter int FIFO_AW = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_16bd,
  input  logic       rx,
  input  logic       cfg_wr,
  input  logic [2:0] cfg_baud,
  input  logic       cfg_parity,
  input  logic       cfg_parity_type,
  input  logic       cfg_stop_bits,
  input  logic [3:0] cfg_frame_length,
  output logic       cfg_busy,
  output logic       cfg_err,
  output logic [2:0] baud,
  output logic       baud_ready,
  output logic       parity,
  output logic       parity_type,
  output logic       stop_bits,
  output logic [3:0] frame_length,
  input  logic [8:0] frame,
  input  logic       frame_valid,
  input  logic       rd_en,
  output logic [8:0] rd_data,
  output logic       rd_valid,
  output logic       ovf,
  input  logic       ovf_clr
`ifdef UART_CTRL_STATS_EN
  ,
  output logic [15:0] stat_frames,
  output logic [15:0] stat_drops
`endif
);
  localparam int IW = $clog2(IDLE_TICKS + 1);
  localparam int CW = $clog2((LOAD_CYCLES > SETTLE_CYCLES ? LOAD_CYCLES : SETTLE_CYCLES) + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TICKS);
  localparam logic [CW-1:0] LOAD_LAST = CW'(LOAD_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  typedef enum logic [1:0] {RUN, DRAIN, LOAD, SETTLE} state_t;
  state_t state;
  logic [IW-1:0] idle_cnt;
  logic [CW-1:0] cnt;
  logic [2:0] sh_baud;
  logic sh_parity, sh_parity_type, sh_stop_bits;
  logic [3:0] sh_len;
  logic fv_q, edge_fv, accept, full, do_pop, do_push, overflow, legal;
  logic [FIFO_AW:0] wp, rp;
  logic [8:0] mem [2**FIFO_AW];
  assign rd_valid = wp != rp;
  assign rd_data = mem[rp[FIFO_AW-1:0]];
  always_comb begin
    legal = cfg_frame_length >= 4'd5 && cfg_frame_length <= 4'd9;
    edge_fv = frame_valid & ~fv_q;
    accept = edge_fv & (state == RUN || state == DRAIN);
    full = wp[FIFO_AW] != rp[FIFO_AW] && wp[FIFO_AW-1:0] == rp[FIFO_AW-1:0];
    do_pop = rd_en & rd_valid;
    do_push = accept & (~full | do_pop);
    overflow = accept & full & ~do_pop;
  end
  always_ff @(posedge clk)
    if (!rst) idle_cnt <= '0;
    else if (tick_16bd) idle_cnt <= !rx ? '0 : idle_cnt == IDLE_MAX ? idle_cnt : idle_cnt + 1'b1;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= LOAD;
      cnt <= '0;
      baud_ready <= 1'b0;
      cfg_busy <= 1'b1;
      cfg_err <= 1'b0;
      baud <= DEF_BAUD;
      parity <= 1'b0;
      parity_type <= 1'b0;
      stop_bits <= 1'b0;
      frame_length <= DEF_LEN;
      sh_baud <= DEF_BAUD;
      sh_parity <= 1'b0;
      sh_parity_type <= 1'b0;
      sh_stop_bits <= 1'b0;
      sh_len <= DEF_LEN;
    end else begin
      cfg_err <= 1'b0;
      case (state)
        RUN:
          if (cfg_wr && legal) begin
            sh_baud <= cfg_baud;
            sh_parity <= cfg_parity;
            sh_parity_type <= cfg_parity_type;
            sh_stop_bits <= cfg_stop_bits;
            sh_len <= cfg_frame_length;
            cfg_busy <= 1'b1;
            state <= DRAIN;
          end else if (cfg_wr) cfg_err <= 1'b1;
        DRAIN:
          if (idle_cnt == IDLE_MAX) begin
            baud <= sh_baud;
            parity <= sh_parity;
            parity_type <= sh_parity_type;
            stop_bits <= sh_stop_bits;
            frame_length <= sh_len;
            baud_ready <= 1'b0;
            cnt <= '0;
            state <= LOAD;
          end
        LOAD:
          if (cnt == LOAD_LAST) begin
            baud_ready <= 1'b1;
            cnt <= '0;
            state <= SETTLE;
          end else cnt <= cnt + 1'b1;
        SETTLE:
          if (cnt == SETTLE_LAST) begin
            cfg_busy <= 1'b0;
            state <= RUN;
          end else cnt <= cnt + 1'b1;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wp[FIFO_AW-1:0]] <= frame;
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      ovf <= 1'b0;
      fv_q <= 1'b0;
    end else begin
      fv_q <= frame_valid;
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
      ovf <= overflow | (ovf & ~ovf_clr);
    end
  end
`ifdef UART_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_frames <= '0;
      stat_drops <= '0;
    end else begin
      stat_frames <= do_push && stat_frames != 16'hFFFF ? stat_frames + 1'b1 : stat_frames;
      stat_drops <= (overflow || (edge_fv && !accept)) && stat_drops != 16'hFFFF ? stat_drops + 1'b1 : stat_drops;
    end
  end
`endif
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick_16bd = 1'b0;
  logic rx = 1'b1;
  logic cfg_wr = 1'b0;
  logic [2:0] cfg_baud = '0;
  logic cfg_parity = 1'b0;
  logic cfg_parity_type = 1'b0;
  logic cfg_stop_bits = 1'b0;
  logic [3:0] cfg_frame_length = '0;
  logic cfg_busy, cfg_err, baud_ready, parity, parity_type, stop_bits, rd_valid, ovf;
  logic [2:0] baud;
  logic [3:0] frame_length;
  logic [8:0] frame = '0;
  logic frame_valid = 1'b0;
  logic rd_en = 1'b0;
  logic ovf_clr = 1'b0;
  logic [8:0] rd_data;
  int errors = 0;
  int checks = 0;
  uart_rx_ctrl dut (
    .clk(clk), .rst(rst), .tick_16bd(tick_16bd), .rx(rx),
    .cfg_wr(cfg_wr), .cfg_baud(cfg_baud), .cfg_parity(cfg_parity),
    .cfg_parity_type(cfg_parity_type), .cfg_stop_bits(cfg_stop_bits),
    .cfg_frame_length(cfg_frame_length), .cfg_busy(cfg_busy), .cfg_err(cfg_err),
    .baud(baud), .baud_ready(baud_ready), .parity(parity), .parity_type(parity_type),
    .stop_bits(stop_bits), .frame_length(frame_length), .frame(frame),
    .frame_valid(frame_valid), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic cfg(input logic [2:0] b, input logic p, input logic pt, input logic sb, input logic [3:0] l);
    cfg_baud = b;
    cfg_parity = p;
    cfg_parity_type = pt;
    cfg_stop_bits = sb;
    cfg_frame_length = l;
    cfg_wr = 1'b1;
    cyc(1);
    cfg_wr = 1'b0;
  endtask
  task automatic push(input logic [8:0] v);
    frame = v;
    frame_valid = 1'b1;
    cyc(1);
    frame_valid = 1'b0;
    cyc(1);
  endtask
  task automatic pop();
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
  endtask
  initial begin
    cyc(2);
    chk("rst_br", baud_ready, 0);
    chk("rst_busy", cfg_busy, 1);
    chk("rst_valid", rd_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_baud", baud, 3'b010);
    chk("rst_len", frame_length, 8);
    rst = 1'b1;
    tick_16bd = 1'b1;
    cyc(1);
    chk("load1_br", baud_ready, 0);
    cyc(1);
    chk("settle_br", baud_ready, 1);
    chk("settle_busy", cfg_busy, 1);
    cyc(15);
    chk("settle15_busy", cfg_busy, 1);
    cyc(1);
    chk("run_busy", cfg_busy, 0);
    chk("run_baud", baud, 3'b010);
    chk("run_len", frame_length, 8);
    cyc(20);
    cfg(3'b000, 0, 0, 0, 4'd10);
    chk("bad_err", cfg_err, 1);
    chk("bad_busy", cfg_busy, 0);
    cyc(1);
    chk("bad_err_end", cfg_err, 0);
    chk("bad_len", frame_length, 8);
    cfg(3'b100, 1, 1, 1, 4'd7);
    chk("drain_busy", cfg_busy, 1);
    chk("drain_br", baud_ready, 1);
    chk("drain_baud", baud, 3'b010);
    cyc(1);
    chk("load_br", baud_ready, 0);
    chk("load_baud", baud, 3'b100);
    chk("load_par", parity, 1);
    chk("load_pt", parity_type, 1);
    chk("load_sb", stop_bits, 1);
    chk("load_len", frame_length, 7);
    cyc(1);
    chk("load2_br", baud_ready, 0);
    cyc(1);
    chk("settle_br2", baud_ready, 1);
    cfg(3'b001, 0, 0, 0, 4'd10);
    chk("settle_noerr", cfg_err, 0);
    cfg(3'b001, 0, 0, 0, 4'd5);
    chk("settle_noerr2", cfg_err, 0);
    cyc(13);
    chk("settle_end_busy", cfg_busy, 1);
    cyc(1);
    chk("run2_busy", cfg_busy, 0);
    chk("run2_baud", baud, 3'b100);
    chk("run2_len", frame_length, 7);
    for (int i = 0; i < 9; i++) push(9'(9'h055 + i));
    chk("ovf_valid", rd_valid, 1);
    chk("ovf_set", ovf, 1);
    chk("ovf_head", rd_data, 9'h055);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_pop", rd_data, 32'(9'h055 + i));
      pop();
    end
    chk("ovf_empty", rd_valid, 0);
    pop();
    chk("empty_pop", rd_valid, 0);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", ovf, 0);
    for (int i = 0; i < 8; i++) push(9'(9'h010 + i));
    chk("full_ovf", ovf, 0);
    chk("full_head", rd_data, 9'h010);
    frame = 9'h018;
    frame_valid = 1'b1;
    rd_en = 1'b1;
    cyc(1);
    frame_valid = 1'b0;
    rd_en = 1'b0;
    chk("pp_ovf", ovf, 0);
    chk("pp_head", rd_data, 9'h011);
    cyc(1);
    for (int i = 0; i < 8; i++) begin
      chk("pp_pop", rd_data, 32'(9'h011 + i));
      pop();
    end
    chk("pp_empty", rd_valid, 0);
    chk("pp_ovf_end", ovf, 0);
    rx = 1'b0;
    cyc(3);
    cfg(3'b001, 0, 0, 0, 4'd5);
    chk("busy_rxlow", cfg_busy, 1);
    chk("baud_rxlow", baud, 3'b100);
    push(9'h1A5);
    chk("drain_push_valid", rd_valid, 1);
    chk("drain_push_data", rd_data, 9'h1A5);
    cyc(5);
    chk("drain_hold_baud", baud, 3'b100);
    rx = 1'b1;
    cyc(32);
    chk("idle32_baud", baud, 3'b100);
    chk("idle32_br", baud_ready, 1);
    cyc(1);
    chk("idle33_baud", baud, 3'b001);
    chk("idle33_br", baud_ready, 0);
    chk("idle33_len", frame_length, 5);
    chk("idle33_par", parity, 0);
    cyc(2);
    chk("settle3_br", baud_ready, 1);
    push(9'h0AA);
    chk("settle_drop", rd_data, 9'h1A5);
    chk("settle_drop_ovf", ovf, 0);
    pop();
    chk("settle_drop_empty", rd_valid, 0);
    cyc(13);
    chk("run3_busy", cfg_busy, 0);
    rx = 1'b0;
    cyc(1);
    cfg(3'b110, 1, 0, 1, 4'd9);
    chk("mid_busy", cfg_busy, 1);
    cyc(3);
    rst = 1'b0;
    cyc(1);
    chk("mid_rst_baud", baud, 3'b010);
    chk("mid_rst_len", frame_length, 8);
    chk("mid_rst_par", parity, 0);
    chk("mid_rst_br", baud_ready, 0);
    chk("mid_rst_busy", cfg_busy, 1);
    rst = 1'b1;
    cyc(2);
    chk("mid_settle_br", baud_ready, 1);
    cyc(16);
    chk("mid_run_busy", cfg_busy, 0);
    chk("mid_run_baud", baud, 3'b010);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
